// File: rtl/mmio_pkg.sv
// Shared address-map constants for the switch/LED/timer MMIO responder.
package mmio_pkg;
    localparam logic [31:0] MMIO_BASE = 32'hC000_0000;

    localparam logic [7:0] SW_OFS    = 8'h00;
    localparam logic [7:0] LED_OFS   = 8'h04;
    localparam logic [7:0] EDGE_OFS  = 8'h08;
    localparam logic [7:0] LOAD_OFS  = 8'h0C;
    localparam logic [7:0] CTRL_OFS  = 8'h10;
    localparam logic [7:0] STAT_OFS  = 8'h14;
    localparam logic [7:0] COUNT_OFS = 8'h18;
endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for an asynchronous input bus.
module sync2 #(
    parameter int W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    logic [W-1:0] meta_q;
    logic [W-1:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta_q <= '0;
            sync_q <= '0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/mmio_switch_timer.sv
// MMIO responder: synchronized switches with sticky edge flags, LED register,
// and a prescaled countdown timer with sticky expiry / interrupt output.
module mmio_switch_timer
    import mmio_pkg::*;
#(
    parameter logic [31:0] BASE     = MMIO_BASE,
    parameter int          NSW      = 10,
    parameter int          PRESCALE = 1
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           MemWrite,
    input  logic [31:0]    DataAdr,
    input  logic [31:0]    WriteData,
    output logic [31:0]    ReadData,
    output logic           sel,
    input  logic [NSW-1:0] switches,
    output logic [NSW-1:0] leds,
    output logic           timer_irq
);
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

    logic [NSW-1:0] sw_s;
    logic [NSW-1:0] sw_d_q, sw_d_d;
    logic [NSW-1:0] led_q, led_d;
    logic [NSW-1:0] edge_q, edge_d;
    logic [31:0]    load_q, load_d;
    logic [31:0]    count_q, count_d;
    logic           en_q, en_d;
    logic           auto_q, auto_d;
    logic           exp_q, exp_d;
    logic [PW-1:0]  pre_q, pre_d;

    logic [7:0] ofs;
    logic       wr_en;
    logic       tick;
    logic       unused_adr;

    sync2 #(.W(NSW)) u_sw_sync (
        .clk   (clk),
        .reset (reset),
        .d     (switches),
        .q     (sw_s)
    );

    assign sel        = (DataAdr[31:8] == BASE[31:8]);
    assign ofs        = {DataAdr[7:2], 2'b00};
    assign wr_en      = MemWrite & sel;
    assign tick       = en_q & (pre_q == PRE_LAST);
    assign unused_adr = ^DataAdr[1:0];

    always_comb begin
        sw_d_d  = sw_s;
        led_d   = led_q;
        load_d  = load_q;
        count_d = count_q;
        en_d    = en_q;
        auto_d  = auto_q;
        exp_d   = exp_q;
        pre_d   = (en_q && !tick) ? pre_q + PW'(1) : '0;

        // Clears are applied first so that a same-edge set overrides them.
        edge_d = edge_q;
        if (wr_en && ofs == EDGE_OFS) edge_d = edge_q & ~WriteData[NSW-1:0];
        edge_d = edge_d | (sw_s & ~sw_d_q);
        if (wr_en && ofs == STAT_OFS && WriteData[0]) exp_d = 1'b0;

        if (wr_en && ofs == LED_OFS) led_d = WriteData[NSW-1:0];
        if (wr_en && ofs == CTRL_OFS) begin
            en_d   = WriteData[0];
            auto_d = WriteData[1];
        end

        // A LOAD write pre-empts any tick on the same edge.
        if (wr_en && ofs == LOAD_OFS) begin
            load_d  = WriteData;
            count_d = WriteData;
        end else if (tick) begin
            if (count_q > 32'd1) begin
                count_d = count_q - 32'd1;
            end else if (count_q == 32'd1) begin
                exp_d   = 1'b1;
                count_d = auto_q ? load_q : 32'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sw_d_q  <= '0;
            led_q   <= '0;
            edge_q  <= '0;
            load_q  <= '0;
            count_q <= '0;
            en_q    <= 1'b0;
            auto_q  <= 1'b0;
            exp_q   <= 1'b0;
            pre_q   <= '0;
        end else begin
            sw_d_q  <= sw_d_d;
            led_q   <= led_d;
            edge_q  <= edge_d;
            load_q  <= load_d;
            count_q <= count_d;
            en_q    <= en_d;
            auto_q  <= auto_d;
            exp_q   <= exp_d;
            pre_q   <= pre_d;
        end
    end

    always_comb begin
        ReadData = '0;
        if (sel) begin
            case (ofs)
                SW_OFS:    ReadData = 32'(sw_s);
                LED_OFS:   ReadData = 32'(led_q);
                EDGE_OFS:  ReadData = 32'(edge_q);
                LOAD_OFS:  ReadData = load_q;
                CTRL_OFS:  ReadData = {30'b0, auto_q, en_q};
                STAT_OFS:  ReadData = {31'b0, exp_q};
                COUNT_OFS: ReadData = count_q;
                default:   ReadData = '0;
            endcase
        end
    end

    assign leds      = led_q;
    assign timer_irq = exp_q;
endmodule

// File: tb/tb_mmio_switch_timer.sv
// Randomized bench for mmio_switch_timer: two instances (PRESCALE 1 and 3) on a
// shared bus, checked against a behavioural model plus directed scenarios.
module tb_mmio_switch_timer;
    localparam logic [31:0] BASE = 32'hC000_0000;
    localparam int          NSW  = 10;

    logic           clk = 1'b0;
    logic           reset = 1'b0;
    logic           MemWrite = 1'b0;
    logic [31:0]    DataAdr = '0;
    logic [31:0]    WriteData = '0;
    logic [NSW-1:0] switches = '0;
    logic [31:0]    rd0, rd1;
    logic           sel0, sel1, irq0, irq1;
    logic [NSW-1:0] leds0, leds1;

    int checks = 0;
    int failures = 0;

    mmio_switch_timer #(.BASE(BASE), .NSW(NSW), .PRESCALE(1)) dut0 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(rd0), .sel(sel0), .switches(switches),
        .leds(leds0), .timer_irq(irq0)
    );

    mmio_switch_timer #(.BASE(BASE), .NSW(NSW), .PRESCALE(3)) dut1 (
        .clk(clk), .reset(reset), .MemWrite(MemWrite), .DataAdr(DataAdr),
        .WriteData(WriteData), .ReadData(rd1), .sel(sel1), .switches(switches),
        .leds(leds1), .timer_irq(irq1)
    );

    always #5 clk = ~clk;

    // Behavioural model: shared bus-visible state plus per-instance timer state.
    logic [NSW-1:0] m_s1, m_sws, m_swd, m_led, m_edge;
    logic [31:0]    m_load;
    logic           m_en, m_auto;
    logic [31:0]    m_count [2];
    logic           m_exp [2];
    int             m_run [2];

    logic [31:0]    o_rd0, o_rd1;
    logic           o_sel0, o_irq0, o_irq1;
    logic [NSW-1:0] o_leds0;

    function automatic int pre_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic in_win(input logic [31:0] adr);
        return adr[31:8] == BASE[31:8];
    endfunction

    function automatic logic [31:0] m_read(input int k, input logic [31:0] adr);
        logic [7:0] o;
        o = {adr[7:2], 2'b00};
        if (!in_win(adr)) return 32'd0;
        case (o)
            8'h00:   return 32'(m_sws);
            8'h04:   return 32'(m_led);
            8'h08:   return 32'(m_edge);
            8'h0C:   return m_load;
            8'h10:   return {30'b0, m_auto, m_en};
            8'h14:   return {31'b0, m_exp[k]};
            8'h18:   return m_count[k];
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_s1 = '0; m_sws = '0; m_swd = '0; m_led = '0; m_edge = '0;
        m_load = '0; m_en = 1'b0; m_auto = 1'b0;
        for (int k = 0; k < 2; k++) begin
            m_count[k] = '0; m_exp[k] = 1'b0; m_run[k] = 0;
        end
    endtask

    task automatic model_step(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        logic           hit;
        logic [7:0]     o;
        logic [NSW-1:0] rise;
        logic           tk;
        hit  = we && in_win(adr);
        o    = {adr[7:2], 2'b00};
        rise = m_sws & ~m_swd;
        for (int k = 0; k < 2; k++) begin
            // The timer ticks on every PRESCALE-th cycle of continuous enable.
            tk = m_en && ((m_run[k] % pre_of(k)) == pre_of(k) - 1);
            if (hit && o == 8'h14 && wd[0]) m_exp[k] = 1'b0;
            if (hit && o == 8'h0C) begin
                m_count[k] = wd;
            end else if (tk && m_count[k] > 1) begin
                m_count[k] = m_count[k] - 1;
            end else if (tk && m_count[k] == 1) begin
                m_exp[k]   = 1'b1;
                m_count[k] = m_auto ? m_load : 32'd0;
            end
            m_run[k] = m_en ? m_run[k] + 1 : 0;
        end
        if (hit && o == 8'h0C) m_load = wd;
        if (hit && o == 8'h10) begin
            m_en   = wd[0];
            m_auto = wd[1];
        end
        if (hit && o == 8'h04) m_led = wd[NSW-1:0];
        if (hit && o == 8'h08) m_edge = m_edge & ~wd[NSW-1:0];
        m_edge = m_edge | rise;
        m_swd  = m_sws;
        m_sws  = m_s1;
        m_s1   = switches;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Called at a negedge: drive, observe, advance one clock, return at negedge.
    task automatic cycle(input logic we, input logic [31:0] adr, input logic [31:0] wd);
        MemWrite = we; DataAdr = adr; WriteData = wd;
        #1;
        o_rd0 = rd0; o_rd1 = rd1; o_sel0 = sel0; o_irq0 = irq0; o_irq1 = irq1; o_leds0 = leds0;
        check("sel0", 32'(sel0), 32'(in_win(adr)));
        check("sel1", 32'(sel1), 32'(in_win(adr)));
        check("rd0", rd0, m_read(0, adr));
        check("rd1", rd1, m_read(1, adr));
        check("leds0", 32'(leds0), 32'(m_led));
        check("leds1", 32'(leds1), 32'(m_led));
        check("irq0", 32'(irq0), 32'(m_exp[0]));
        check("irq1", 32'(irq1), 32'(m_exp[1]));
        @(posedge clk);
        if (reset) model_reset();
        else model_step(we, adr, wd);
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_irq0"}, 32'(irq0), 32'd0);
        check({tag, "_irq1"}, 32'(irq1), 32'd0);
        check({tag, "_leds0"}, 32'(leds0), 32'd0);
        check({tag, "_leds1"}, 32'(leds1), 32'd0);
        check({tag, "_rd0"}, rd0, 32'd0);
        check({tag, "_rd1"}, rd1, 32'd0);
    endtask

    initial begin
        logic [31:0] adr, wd;
        logic [7:0]  o;
        int          r;

        model_reset();
        DataAdr = BASE + 32'h18;
        #3 reset = 1'b1;
        #1 reset_checks("por");
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, BASE + 32'(i * 4), 32'd0);
            check("reset_read", o_rd0, 32'd0);
        end
        reset = 1'b0;

        // LED register and address decode.
        cycle(1'b1, BASE + 32'h4, 32'h2A5);
        cycle(1'b0, BASE + 32'h4, 32'd0);
        check("led_out", 32'(o_leds0), 32'h2A5);
        check("led_rd", o_rd0, 32'h2A5);
        cycle(1'b1, 32'hC000_0104, 32'h155);
        check("oow_sel", 32'(o_sel0), 32'd0);
        check("oow_rd", o_rd0, 32'd0);
        cycle(1'b0, BASE + 32'h4, 32'd0);
        check("led_keep", 32'(o_leds0), 32'h2A5);

        // Switch synchronizer and sticky edge flags.
        switches = '0;
        repeat (4) cycle(1'b0, BASE, 32'd0);
        switches = 10'h008;
        cycle(1'b0, BASE, 32'd0);
        cycle(1'b0, BASE, 32'd0);
        check("sw_1edge", o_rd0, 32'd0);
        cycle(1'b0, BASE + 32'h8, 32'd0);
        check("edge_2edge", o_rd0, 32'd0);
        cycle(1'b0, BASE, 32'd0);
        check("sw_3edge", o_rd0, 32'h008);
        cycle(1'b1, BASE + 32'h8, 32'h008);
        check("edge_set", o_rd0, 32'h008);
        cycle(1'b0, BASE + 32'h8, 32'd0);
        check("edge_w1c", o_rd0, 32'd0);
        switches = '0;
        repeat (4) cycle(1'b0, BASE + 32'h8, 32'd0);
        check("edge_fall", o_rd0, 32'd0);
        switches = 10'h008;
        cycle(1'b0, BASE + 32'h8, 32'd0);
        cycle(1'b0, BASE + 32'h8, 32'd0);
        cycle(1'b1, BASE + 32'h8, 32'h008);
        cycle(1'b0, BASE + 32'h8, 32'd0);
        check("edge_set_wins", o_rd0, 32'h008);

        // One-shot countdown on the PRESCALE=1 instance.
        cycle(1'b1, BASE + 32'hC, 32'd5);
        cycle(1'b1, BASE + 32'h10, 32'd1);
        for (int i = 0; i <= 5; i++) begin
            cycle(1'b0, BASE + 32'h18, 32'd0);
            check("oneshot_cnt", o_rd0, 32'(5 - i));
            check("oneshot_irq", 32'(o_irq0), 32'(i == 5));
        end
        cycle(1'b0, BASE + 32'h18, 32'd0);
        check("oneshot_hold", o_rd0, 32'd0);

        // Auto-reload with PRESCALE=3, clearing STAT every cycle.
        cycle(1'b1, BASE + 32'h10, 32'd0);
        cycle(1'b1, BASE + 32'h14, 32'd1);
        cycle(1'b1, BASE + 32'hC, 32'd2);
        cycle(1'b1, BASE + 32'h10, 32'd3);
        for (int i = 0; i <= 12; i++) begin
            cycle(1'b1, BASE + 32'h14, 32'd1);
            check("auto_irq", 32'(o_irq1), 32'(i == 6 || i == 12));
        end

        // LOAD write racing the final tick.
        cycle(1'b1, BASE + 32'h10, 32'd0);
        cycle(1'b1, BASE + 32'h14, 32'd1);
        cycle(1'b1, BASE + 32'hC, 32'd3);
        cycle(1'b1, BASE + 32'h10, 32'd1);
        cycle(1'b0, BASE + 32'h18, 32'd0);
        check("race_cnt3", o_rd0, 32'd3);
        cycle(1'b0, BASE + 32'h18, 32'd0);
        check("race_cnt2", o_rd0, 32'd2);
        cycle(1'b1, BASE + 32'hC, 32'd7);
        cycle(1'b0, BASE + 32'h18, 32'd0);
        check("race_cnt7", o_rd0, 32'd7);
        check("race_noexp", 32'(o_irq0), 32'd0);

        // Randomized traffic with a mid-run asynchronous reset.
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       adr = BASE + 32'(r * 4) + 32'($urandom_range(0, 3));
            else if (r == 8) adr = BASE + 32'h40;
            else             adr = 32'hC000_0100 + 32'($urandom_range(0, 7) * 4);
            o = {adr[7:2], 2'b00};
            if (o == 8'h0C)      wd = 32'($urandom_range(0, 8));
            else if (o == 8'h10) wd = 32'($urandom_range(0, 3));
            else                 wd = $urandom;
            if ($urandom_range(0, 4) == 0) switches = switches ^ NSW'($urandom);
            cycle(1'($urandom_range(0, 1)), adr, wd);
            if (n == 200) begin
                DataAdr = BASE + 32'h18;
                #2 reset = 1'b1;
                model_reset();
                #1 reset_checks("async");
                cycle(1'b0, BASE + 32'h18, 32'd0);
                cycle(1'b1, BASE + 32'h4, 32'h3FF);
                reset = 1'b0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/mmio_switch_timer.md
# mmio_switch_timer

Memory-mapped peripheral responder on the ARM single-cycle processor's data bus, alongside the data RAM inside the data-memory block. It decodes processor loads and stores in its address window and provides:
- a synchronized switch input with sticky rising-edge flags;
- a writable LED register;
- a prescaled countdown timer with a sticky expiry flag and interrupt-style output.

The data-memory read mux uses `sel` to choose this block's `ReadData` over RAM.

## Interface
Parameters:
- `BASE`, default 32'hC000_0000: window base address; the window is 256 bytes, decoded on `DataAdr[31:8]`.
- `NSW`, default 10: width of the switch and LED buses.
- `PRESCALE`, default 1: clock cycles per timer decrement, minimum 1.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high.
- `MemWrite` in 1: store strobe from the processor.
- `DataAdr` in 32: byte address from the processor.
- `WriteData` in 32: store data.
- `ReadData` out 32: combinational load data. Zero when `sel`=0.
- `sel` out 1: combinational, high when `DataAdr` is in the window.
- `switches` in NSW: asynchronous board switches.
- `leds` out NSW: LED register output.
- `timer_irq` out 1: equals the EXPIRED flag.

## Operation
Register map (word offsets; `DataAdr[1:0]` ignored). Unlisted offsets read 0 and ignore writes. Unused upper bits read 0.
- 0x00 SW (RO): synchronized switch value.
- 0x04 LED (RW): drives `leds`.
- 0x08 EDGE (RO, W1C): per-switch sticky rising-edge flags.
- 0x0C LOAD (RW, 32b): writing it also loads COUNT.
- 0x10 CTRL (RW): bit0 EN, bit1 AUTO.
- 0x14 STAT (RO, W1C): bit0 EXPIRED.
- 0x18 COUNT (RO): current count.

Writes take effect on the rising edge where `MemWrite` & `sel` & offset match.

Switch path:
- `switches` pass through a 2-FF synchronizer to give `sw_s`, then one more register to give `sw_d`.
- EDGE[i] is set when `sw_s[i]` & ~`sw_d[i]`.
- A W1C write clears the bits written as 1.
- If set and clear hit the same bit on the same edge, set wins.

Timer:
- A prescale counter runs while EN=1 and wraps at PRESCALE-1, producing a one-cycle tick. Clearing EN resets the prescale counter.
- On a tick with COUNT>1: COUNT decrements.
- On a tick with COUNT==1: EXPIRED is set. COUNT becomes LOAD if AUTO=1, otherwise 0.
- On a tick with COUNT==0: no change; the timer is stopped.
- A LOAD write on the same edge as a tick: the write wins (COUNT = new LOAD) and no expiry occurs.
- EXPIRED set and W1C clear on the same edge: set wins.

Arithmetic: COUNT and LOAD are 32-bit unsigned. Decrement never wraps below 0.

## Timing
- Reset values: `leds`=0, LED=0, EDGE=0, LOAD=0, COUNT=0, CTRL=0, EXPIRED=0, `timer_irq`=0, synchronizer and prescaler=0.
- `ReadData` and `sel` are purely combinational on `DataAdr` and register state, with zero-cycle read latency, as required by the single-cycle core.
- Store effects are visible to a load in the next cycle.
- Switch change to SW readback: 2 edges. Switch change to EDGE flag: 3 edges.
- With PRESCALE=1, EN=1, LOAD=N: EXPIRED rises N edges after the first edge with EN=1.
- `reset` asserted mid-count clears everything immediately, independent of `clk`.

## Structure
- Package `mmio_pkg`: `BASE` default and the register offset constants (`SW_OFS`, `LED_OFS`, `EDGE_OFS`, `LOAD_OFS`, `CTRL_OFS`, `STAT_OFS`, `COUNT_OFS`).
- Sub-module `sync2`: parameterized-width 2-FF synchronizer with asynchronous reset, instantiated once for the switch bus.
- Timer and prescaler live in the top of this block; no further hierarchy.

## Test plan
- Reset: assert `reset` async mid-cycle -> every output is 0 and all reads return 0.
- LED and decode: store 0x2A5 to BASE+4 -> `leds`=0x2A5 on the next edge and the load reads 0x2A5; store to 0xC000_0104 -> `sel`=0 and `leds` unchanged.
- Switch edge: raise switch 3 -> SW bit3 set after 2 edges, EDGE=0x008 after 3 edges; write 0x008 to EDGE -> EDGE=0. Setting and clearing on the same edge -> EDGE stays 0x008.
- One-shot timer: LOAD=5, CTRL=1, PRESCALE=1 -> COUNT reads 4,3,2,1 then 0 with EXPIRED=1 and `timer_irq`=1 on the 5th edge; COUNT holds at 0.
- Auto-reload with prescale: PRESCALE=3, LOAD=2, CTRL=3 -> EXPIRED every 6 cycles; write 1 to STAT on an expiry edge -> EXPIRED stays 1.
- Reload race: a LOAD=7 write on the same edge as the COUNT==1 tick -> COUNT=7 and EXPIRED stays 0.
